mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 42 ++++
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: EX/MEM controls and operands in, stall/branch select and MEM/WB results out.
// Purely structural, no latency of its own.
// Stall is driven by the stage and must freeze every upstream-driven signal while high.
interface mem_wb_stage_if;
    // EX/MEM register outputs presented to the stage
    logic        RegWrite;
    logic        Branch;
    logic        MemWrite;
    logic        MemRead;
    logic        MemToReg;
    logic        Zero;
    logic [63:0] ALUResult;
    logic [31:0] WriteMemData;
    logic [4:0]  WriteReg;

    // stage results
    logic        Stall;
    logic        PCSrcOut;
    logic        RegWriteOut;
    logic        MemToRegOut;
    logic [31:0] ReadDataOut;
    logic [63:0] ALUResultOut;
    logic [4:0]  WriteRegOut;
    logic        MemFaultOut;
    logic [63:0] WriteBackData;

    // upstream pipeline side
    modport master (
        output RegWrite, Branch, MemWrite, MemRead, MemToReg, Zero,
               ALUResult, WriteMemData, WriteReg,
        input  Stall, PCSrcOut, RegWriteOut, MemToRegOut, ReadDataOut,
               ALUResultOut, WriteRegOut, MemFaultOut, WriteBackData
    );

    // the MEM/WB stage itself
    modport slave (
        input  RegWrite, Branch, MemWrite, MemRead, MemToReg, Zero,
               ALUResult, WriteMemData, WriteReg,
        output Stall, PCSrcOut, RegWriteOut, MemToRegOut, ReadDataOut,
               ALUResultOut, WriteRegOut, MemFaultOut, WriteBackData
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: data-memory access with fixed multi-cycle latency, fault detection, MEM/WB register, write-back mux.
// Latency: memory ops complete on the MEM_LAT-th edge (MEM_LAT-1 stall cycles); ALU ops and faults take one edge.
// Backpressure: Stall high tells upstream to hold inputs; the MEM/WB register takes bubbles while stalled.
module mem_wb_stage #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_wb_stage_if.slave bus
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic        MULTI    = (MEM_LAT > 1);
    // first BUSY cycle counter value; the cycle where it reads 0 is the completing one
    localparam logic [1:0]  CNT_INIT = MULTI ? 2'(MEM_LAT - 2) : 2'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [31:0] mem [DEPTH];

    logic                  rw_q;
    logic                  m2r_q;
    logic [31:0]           rd_q;
    logic [63:0]           alu_q;
    logic [4:0]            wr_q;
    logic                  flt_q;

    logic [DEPTH_LOG2-1:0] addr;
    logic                  req;
    logic                  fault;
    logic                  go_busy;
    logic                  stall_raw;
    logic                  complete;
    logic                  mem_we;
    logic [31:0]           rd_word;

    assign addr    = bus.ALUResult[DEPTH_LOG2+1:2];
    assign req     = bus.MemRead ^ bus.MemWrite;
    // conflicting controls, misaligned word, or address beyond the memory all fault
    assign fault   = (bus.MemRead & bus.MemWrite)
                   | (req & ((bus.ALUResult[1:0] != 2'b00)
                          | (bus.ALUResult[63:DEPTH_LOG2+2] != '0)));
    assign go_busy = req & ~fault & MULTI;
    assign rd_word = mem[addr];

    // next-state, latency counter and raw stall decision
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_busy) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_INIT;
                    stall_raw = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = cnt_q - 2'd1;
                    stall_raw = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // reset forces the stall low immediately; no edge may complete while reset is held
    assign complete = rst_n & ~stall_raw & ~fault;
    assign mem_we   = complete & req & bus.MemWrite;

    // FSM state and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM/WB register: bubble while stalled, fault marker, or the completed instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q  <= 1'b0;
            m2r_q <= 1'b0;
            rd_q  <= 32'd0;
            alu_q <= 64'd0;
            wr_q  <= 5'd0;
            flt_q <= 1'b0;
        end else if (stall_raw) begin
            rw_q  <= 1'b0;
            m2r_q <= 1'b0;
            flt_q <= 1'b0;
        end else if (fault) begin
            rw_q  <= 1'b0;
            m2r_q <= 1'b0;
            rd_q  <= 32'd0;
            alu_q <= bus.ALUResult;
            wr_q  <= bus.WriteReg;
            flt_q <= 1'b1;
        end else begin
            rw_q  <= bus.RegWrite;
            m2r_q <= bus.MemToReg;
            rd_q  <= (req & bus.MemRead) ? rd_word : 32'd0;
            alu_q <= bus.ALUResult;
            wr_q  <= bus.WriteReg;
            flt_q <= 1'b0;
        end
    end

    // data memory: never reset, stores commit only on their completing edge
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= bus.WriteMemData;
        end
    end

    assign bus.Stall         = rst_n & stall_raw;
    assign bus.PCSrcOut      = bus.Branch & bus.Zero;
    assign bus.RegWriteOut   = rw_q;
    assign bus.MemToRegOut   = m2r_q;
    assign bus.ReadDataOut   = rd_q;
    assign bus.ALUResultOut  = alu_q;
    assign bus.WriteRegOut   = wr_q;
    assign bus.MemFaultOut   = flt_q;
    assign bus.WriteBackData = m2r_q ? {32'd0, rd_q} : alu_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a write-back scoreboard and a memory reference model.
// Each instruction is driven at a falling edge and held until Stall drops.
// Write-backs and faults are popped from the scoreboard as the MEM/WB register produces them.
module tb_mem_wb_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage #(
        .MEM_LAT    (2),
        .DEPTH_LOG2 (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        fault;
        logic [4:0]  wreg;
        logic [63:0] wb;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mm [int];
    int          total    = 0;
    int          bad      = 0;
    int          wb_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic [63:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        bus.RegWrite     = rw;
        bus.MemToReg     = m2r;
        bus.MemRead      = mr;
        bus.MemWrite     = mw;
        bus.ALUResult    = alu;
        bus.WriteMemData = wd;
        bus.WriteReg     = wr;
        bus.Branch       = 1'b0;
        bus.Zero         = 1'b0;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // reference model: decides fault/writeback and updates model memory for committed stores
    task automatic model(input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic [63:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        exp_t        e;
        logic        rq;
        logic        flt;
        int          a;
        logic [31:0] rd;
        rq  = mr ^ mw;
        flt = (mr & mw) | (rq & ((alu[1:0] != 2'b00) | (alu[63:10] != 54'd0)));
        a   = int'(alu[9:2]);
        if (flt) begin
            e.fault = 1'b1;
            e.wreg  = wr;
            e.wb    = alu;
            e.rd    = 32'd0;
            sb.push_back(e);
        end else begin
            rd = 32'd0;
            if (rq && mr) rd = mm.exists(a) ? mm[a] : 32'd0;
            if (rq && mw) mm[a] = wd;
            if (rw) begin
                e.fault = 1'b0;
                e.wreg  = wr;
                e.rd    = rd;
                e.wb    = m2r ? {32'd0, rd} : alu;
                sb.push_back(e);
            end
        end
    endtask

    // present one instruction, count its stall cycles, return at the falling edge after completion
    task automatic issue(input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic [63:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input int exp_stalls, input string tag);
        int stalls = 0;
        int guard  = 0;
        drive(rw, m2r, mr, mw, alu, wd, wr);
        model(rw, m2r, mr, mw, alu, wd, wr);
        #1;
        while (bus.Stall === 1'b1 && guard < 10) begin
            stalls++;
            @(posedge clk);
            #1;
            chk({tag, "_bubble"}, {62'd0, bus.RegWriteOut, bus.MemFaultOut}, 64'd0);
            @(negedge clk);
            #1;
            guard++;
        end
        chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
        @(posedge clk);
        @(negedge clk);
    endtask

    // scoreboard consumer: every write-back or fault must match the oldest expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && (bus.RegWriteOut === 1'b1 || bus.MemFaultOut === 1'b1)) begin
            wb_count++;
            if (sb.size() == 0) begin
                chk("unexpected_output", {59'd0, bus.WriteRegOut}, 64'h1f_dead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_fault", {63'd0, bus.MemFaultOut}, {63'd0, e.fault});
                chk("sb_regwrite", {63'd0, bus.RegWriteOut}, {63'd0, ~e.fault});
                chk("sb_readdata", {32'd0, bus.ReadDataOut}, {32'd0, e.rd});
                if (!e.fault) begin
                    chk("sb_wreg", {59'd0, bus.WriteRegOut}, {59'd0, e.wreg});
                    chk("sb_wbdata", bus.WriteBackData, e.wb);
                end
            end
        end
    end

    initial begin
        int wb_before;
        nop();

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {63'd0, bus.Stall}, 64'd0);
        chk("rst_regwrite", {63'd0, bus.RegWriteOut}, 64'd0);
        chk("rst_fault", {63'd0, bus.MemFaultOut}, 64'd0);
        chk("rst_alu", bus.ALUResultOut, 64'd0);
        chk("rst_wbdata", bus.WriteBackData, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // store then load of the same word
        issue(1'b0, 1'b0, 1'b0, 1'b1, 64'h10, 32'hDEADBEEF, 5'd0, 1, "st10");
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h10, 32'd0, 5'd5, 1, "ld10");
        nop();
        #1;
        chk("ld10_rdata", {32'd0, bus.ReadDataOut}, 64'hDEADBEEF);
        chk("ld10_wbdata", bus.WriteBackData, 64'h00000000DEADBEEF);
        chk("ld10_wreg", {59'd0, bus.WriteRegOut}, 64'd5);
        @(negedge clk);

        // misaligned load: no stall, one-cycle fault flag
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h12, 32'd0, 5'd6, 0, "ld12");
        nop();
        #1;
        chk("ld12_fault", {63'd0, bus.MemFaultOut}, 64'd1);
        chk("ld12_regwrite", {63'd0, bus.RegWriteOut}, 64'd0);
        tick();
        #1;
        chk("ld12_fault_clr", {63'd0, bus.MemFaultOut}, 64'd0);
        @(negedge clk);

        // plain ALU op
        issue(1'b1, 1'b0, 1'b0, 1'b0, 64'h5, 32'd0, 5'd3, 0, "alu5");
        nop();
        #1;
        chk("alu5_result", bus.ALUResultOut, 64'd5);
        chk("alu5_wbdata", bus.WriteBackData, 64'd5);
        chk("alu5_regwrite", {63'd0, bus.RegWriteOut}, 64'd1);
        @(negedge clk);

        // other fault kinds; the misaligned store must not touch memory
        issue(1'b1, 1'b1, 1'b1, 1'b1, 64'h10, 32'h1111, 5'd4, 0, "rdwr");
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h400, 32'd0, 5'd4, 0, "ld_oor");
        issue(1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 32'h0BAD, 5'd0, 0, "st_mis");
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h10, 32'd0, 5'd8, 1, "ld10_again");

        // branch select is combinational
        nop();
        bus.Branch = 1'b1;
        bus.Zero   = 1'b1;
        #1;
        chk("pcsrc_taken", {63'd0, bus.PCSrcOut}, 64'd1);
        bus.Zero = 1'b0;
        #1;
        chk("pcsrc_not_taken", {63'd0, bus.PCSrcOut}, 64'd0);
        @(negedge clk);

        // store immediately followed by load of the same address
        issue(1'b0, 1'b0, 1'b0, 1'b1, 64'h24, 32'hCAFEF00D, 5'd0, 1, "st24");
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h24, 32'd0, 5'd10, 1, "ld24");

        // reset during BUSY discards the pending store
        issue(1'b0, 1'b0, 1'b0, 1'b1, 64'h20, 32'hAAAA5555, 5'd7, 1, "st20_pre");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h20, 32'h1234, 5'd7);
        #1;
        chk("st20_stall", {63'd0, bus.Stall}, 64'd1);
        @(posedge clk);
        #2;
        chk("st20_busy_alu_held", bus.ALUResultOut, 64'h20);
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", {63'd0, bus.Stall}, 64'd0);
        chk("midrst_alu", bus.ALUResultOut, 64'd0);
        chk("midrst_wreg", {59'd0, bus.WriteRegOut}, 64'd0);
        chk("midrst_wbdata", bus.WriteBackData, 64'd0);
        nop();
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h20, 32'd0, 5'd9, 1, "ld20_after_rst");

        // three back-to-back loads
        wb_before = wb_count;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h10, 32'd0, 5'd1, 1, "b2b_1");
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h20, 32'd0, 5'd2, 1, "b2b_2");
        issue(1'b1, 1'b1, 1'b1, 1'b0, 64'h24, 32'd0, 5'd3, 1, "b2b_3");
        nop();
        tick();
        tick();
        chk("b2b_wb_count", 64'(wb_count - wb_before), 64'd3);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
